// File: rtl/i2c_pkg.sv
// i2c_pkg: shared widths, state encoding and sizing helper for the I2C master controller.
package i2c_pkg;
    localparam int ADDR_WIDTH = 7;
    localparam int DATA_WIDTH = 8;
    localparam int GAP_CYCLES = 2;
    typedef enum logic [3:0] {
        IDLE, START_H, START_L, ADDR, RW, ACK1, GAP, DATA, ACK2, STOP_L, STOP_H, DONE
    } state_t;
    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction
endpackage

// File: rtl/i2c_shift_tx.sv
// i2c_shift_tx: loadable LSB-first shift register whose bit counter stops at the last bit.
module i2c_shift_tx #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic [CNT_W-1:0] i_last,
    input  logic             i_shift,
    output logic             o_bit,
    output logic             o_bit_next,
    output logic             o_last
);
    logic [WIDTH-1:0] r_sr;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_last_idx;
    logic [WIDTH-1:0] w_sr_next;
    assign w_sr_next  = r_sr >> 1;
    assign o_bit      = r_sr[0];
    assign o_bit_next = w_sr_next[0];
    assign o_last     = r_cnt == r_last_idx;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sr       <= '0;
            r_cnt      <= '0;
            r_last_idx <= '0;
        end else if (i_load) begin
            r_sr       <= i_data;
            r_cnt      <= '0;
            r_last_idx <= i_last;
        end else if (i_shift && !o_last) begin
            r_sr  <= w_sr_next;
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: single-byte I2C-style master; START, LSB-first address, R/W, ACK, data, STOP.
module i2c_master_ctrl
    import i2c_pkg::*;
#(
    parameter int ADDR_WIDTH = i2c_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = i2c_pkg::DATA_WIDTH,
    parameter int GAP_CYCLES = i2c_pkg::GAP_CYCLES
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  SCL,
    output logic                  SDA_OUT,
    input  logic                  ack_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  done,
    output logic                  nack_err,
    output logic                  busy
);
    localparam int SW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CW = cnt_w(SW);
    localparam int GW = cnt_w(GAP_CYCLES);
    state_t                r_state;
    logic                  r_sda;
    logic                  r_done;
    logic                  r_nack;
    logic                  r_write;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [GW-1:0]         r_gap;
    logic                  w_load;
    logic                  w_shift;
    logic                  w_bit;
    logic                  w_bit_next;
    logic                  w_last;
    logic [SW-1:0]         w_load_data;
    logic [CW-1:0]         w_load_last;
    // The shifter holds the address from acceptance and is reloaded with the data byte in RW.
    assign w_load      = (r_state == IDLE && cmd_valid) || r_state == RW;
    assign w_load_data = (r_state == IDLE) ? SW'(cmd_addr) : SW'(r_wdata);
    assign w_load_last = (r_state == IDLE) ? CW'(ADDR_WIDTH - 1) : CW'(DATA_WIDTH - 1);
    assign w_shift     = (r_state == ADDR || r_state == DATA) && !w_last;
    i2c_shift_tx #(.WIDTH(SW), .CNT_W(CW)) u_shift (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_load),
        .i_data    (w_load_data),
        .i_last    (w_load_last),
        .i_shift   (w_shift),
        .o_bit     (w_bit),
        .o_bit_next(w_bit_next),
        .o_last    (w_last)
    );
    assign SCL       = 1'b1;
    assign SDA_OUT   = r_sda;
    assign done      = r_done;
    assign nack_err  = r_nack;
    assign rdata     = r_rdata;
    assign cmd_ready = r_state == IDLE;
    assign busy      = r_state != IDLE;
    // SDA is registered: each transition loads the level the next state drives.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_sda   <= 1'b1;
            r_done  <= 1'b0;
            r_nack  <= 1'b0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_gap   <= '0;
        end else begin
            r_done <= 1'b0;
            r_sda  <= 1'b1;
            case (r_state)
                IDLE: if (cmd_valid) begin
                    r_state <= START_H;
                    r_write <= cmd_write;
                    r_wdata <= cmd_wdata;
                    r_nack  <= 1'b0;
                end
                START_H: begin
                    r_state <= START_L;
                    r_sda   <= 1'b0;
                end
                START_L: begin
                    r_state <= ADDR;
                    r_sda   <= w_bit;
                end
                ADDR: begin
                    r_state <= w_last ? RW : ADDR;
                    r_sda   <= w_last ? r_write : w_bit_next;
                end
                RW: r_state <= ACK1;
                ACK1: begin
                    if (ack_n || !r_write) begin
                        r_nack  <= ack_n;
                        r_state <= STOP_L;
                        r_sda   <= 1'b0;
                    end else if (GAP_CYCLES == 0) begin
                        r_state <= DATA;
                        r_sda   <= w_bit;
                    end else begin
                        r_state <= GAP;
                        r_gap   <= '0;
                    end
                end
                GAP: begin
                    if (r_gap == GW'(GAP_CYCLES - 1)) begin
                        r_state <= DATA;
                        r_sda   <= w_bit;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                DATA: begin
                    r_state <= w_last ? ACK2 : DATA;
                    r_sda   <= w_last ? 1'b1 : w_bit_next;
                end
                ACK2: begin
                    r_nack  <= ack_n;
                    r_state <= STOP_L;
                    r_sda   <= 1'b0;
                end
                STOP_L: r_state <= STOP_H;
                STOP_H: begin
                    r_state <= DONE;
                    r_done  <= 1'b1;
                    if (!r_write && !r_nack) r_rdata <= data_in;
                end
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// tb_i2c_master_ctrl: directed checks of bus sequencing, NACK handling, reset abort and a full address sweep.
module tb_i2c_master_ctrl;
    localparam int NLOG = 32;
    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       SCL;
    logic       SDA_OUT;
    logic       ack_n;
    logic [7:0] data_in;
    logic [7:0] rdata;
    logic       done;
    logic       nack_err;
    logic       busy;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [40:0] sda_log;
    logic [40:0] done_log;
    logic [40:0] busy_log;
    logic [40:0] nack_log;
    logic [7:0]  rd_log [0:40];
    logic [7:0]  mem [0:127];
    always #5 clk = ~clk;
    i2c_master_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .SCL      (SCL),
        .SDA_OUT  (SDA_OUT),
        .ack_n    (ack_n),
        .data_in  (data_in),
        .rdata    (rdata),
        .done     (done),
        .nack_err (nack_err),
        .busy     (busy)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    // Logs cycles T1..NLOG after acceptance; command inputs are scrambled once accepted.
    task automatic run_txn(input logic w, input logic [6:0] a, input logic [7:0] d,
                           input logic a1, input logic a2, input int rst_at, input logic hold);
        int n;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) chk("accept_timeout", 32'(cmd_ready), 1);
        @(posedge clk);
        #1;
        cmd_valid = hold;
        cmd_write = ~w;
        cmd_addr  = ~a;
        cmd_wdata = ~d;
        sda_log = '0;
        done_log = '0;
        busy_log = '0;
        nack_log = '0;
        for (int k = 1; k <= NLOG; k++) begin
            sda_log[k]  = SDA_OUT;
            done_log[k] = done;
            busy_log[k] = busy;
            nack_log[k] = nack_err;
            rd_log[k]   = rdata;
            ack_n = (k == 11) ? a1 : (k == 22) ? a2 : 1'b0;
            reset = (k == rst_at);
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        reset = 1'b0;
        ack_n = 1'b0;
    endtask
    task automatic drain();
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy) chk("drain_timeout", 32'(busy), 0);
    endtask
    initial begin
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr = '0;
        cmd_wdata = '0;
        ack_n = 1'b0;
        data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_scl", 32'(SCL), 1);
        chk("rst_sda", 32'(SDA_OUT), 1);
        chk("rst_rdata", 32'(rdata), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_nack", 32'(nack_err), 0);
        chk("rst_busy", 32'(busy), 0);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_over_valid_busy", 32'(busy), 0);
        chk("rst_over_valid_sda", 32'(SDA_OUT), 1);
        cmd_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_rst", 32'(cmd_ready), 1);
        // Write 7'd5 / 8'hA5 with ACKs
        run_txn(1'b1, 7'd5, 8'hA5, 1'b0, 1'b0, 0, 1'b0);
        chk("w_start", 32'(sda_log[2:1]), 32'b01);
        chk("w_addr", 32'(sda_log[9:3]), 32'h05);
        chk("w_rw", 32'(sda_log[10]), 1);
        chk("w_ack_gap", 32'(sda_log[13:11]), 32'b111);
        chk("w_data", 32'(sda_log[21:14]), 32'hA5);
        chk("w_stop", 32'(sda_log[25:22]), 32'b1101);
        chk("w_done", done_log[31:0], 32'h0200_0000);
        chk("w_nack", 32'(nack_log[25]), 0);
        chk("w_busy", 32'(busy_log[26:1]), 32'h01FF_FFFF);
        chk("w_rdata_kept", 32'(rd_log[26]), 0);
        // Read 7'd100 returning 8'h3C
        data_in = 8'h3C;
        run_txn(1'b0, 7'd100, 8'h00, 1'b0, 1'b0, 0, 1'b0);
        chk("r_addr", 32'(sda_log[9:3]), 32'd100);
        chk("r_rw", 32'(sda_log[10]), 0);
        chk("r_stop", 32'(sda_log[14:11]), 32'b1101);
        chk("r_done", done_log[31:0], 32'h0000_4000);
        chk("r_rdata_before", 32'(rd_log[13]), 0);
        chk("r_rdata", 32'(rd_log[14]), 32'h3C);
        chk("r_nack", 32'(nack_log[14]), 0);
        // Write NACKed at the address phase
        data_in = 8'h11;
        run_txn(1'b1, 7'd9, 8'h55, 1'b1, 1'b0, 0, 1'b0);
        chk("n1_stop", 32'(sda_log[14:11]), 32'b1101);
        chk("n1_done", done_log[31:0], 32'h0000_4000);
        chk("n1_nack", 32'(nack_log[14]), 1);
        chk("n1_nack_hold", 32'(nack_log[32:14]), 32'h7FFFF);
        chk("n1_rdata_kept", 32'(rd_log[14]), 32'h3C);
        // Write NACKed at the data phase; nack_err from before clears on acceptance
        run_txn(1'b1, 7'd3, 8'h0F, 1'b0, 1'b1, 0, 1'b0);
        chk("n2_nack_clear", 32'(nack_log[1]), 0);
        chk("n2_data", 32'(sda_log[21:14]), 32'h0F);
        chk("n2_stop", 32'(sda_log[25:22]), 32'b1101);
        chk("n2_done", done_log[31:0], 32'h0200_0000);
        chk("n2_nack", 32'(nack_log[25]), 1);
        chk("n2_rdata_kept", 32'(rd_log[25]), 32'h3C);
        // Reset during T8 of a write
        run_txn(1'b1, 7'd42, 8'h99, 1'b0, 1'b0, 8, 1'b0);
        chk("rst_mid_sda", 32'(sda_log[9]), 1);
        chk("rst_mid_busy", 32'(busy_log[32:9]), 0);
        chk("rst_mid_done", done_log[31:0], 0);
        chk("rst_mid_nack", 32'(nack_log[9]), 0);
        data_in = 8'h77;
        run_txn(1'b0, 7'd100, 8'h00, 1'b0, 1'b0, 0, 1'b0);
        chk("after_rst_done", done_log[31:0], 32'h0000_4000);
        chk("after_rst_rdata", 32'(rd_log[14]), 32'h77);
        // cmd_valid held through a write to 7'd127
        run_txn(1'b1, 7'd127, 8'hC3, 1'b0, 1'b0, 0, 1'b1);
        chk("b2b_addr", 32'(sda_log[9:3]), 32'h7F);
        chk("b2b_data", 32'(sda_log[21:14]), 32'hC3);
        chk("b2b_busy", 32'(busy_log[25:1]), 32'h01FF_FFFF);
        chk("b2b_done", 32'(done_log[25]), 1);
        chk("b2b_idle_gap", 32'(busy_log[27:26]), 32'b10);
        chk("b2b_start2", 32'(sda_log[28:27]), 32'b01);
        drain();
        // Sweep all addresses with data = address
        for (int i = 0; i < 128; i++) begin
            run_txn(1'b1, 7'(i), 8'(i), 1'b0, 1'b0, 0, 1'b0);
            mem[i] = 8'(i);
        end
        for (int i = 0; i < 128; i++) begin
            data_in = mem[i];
            run_txn(1'b0, 7'(i), 8'h00, 1'b0, 1'b0, 0, 1'b0);
            chk($sformatf("fill_rdata_%0d", i), 32'(rd_log[14]), i);
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
    initial begin
        #5ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
